// File: rtl/digit_scan_ctrl.sv
// Scan controller for a four-digit seven-segment display: double-buffered value,
// frame-aligned updates, per-dwell blanking and lamp test, all outputs registered.
module digit_scan_ctrl #(
  parameter int SCAN_DIV     = 4096,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        lamp_test,
  output logic [3:0]  showDigit,
  output logic [5:0]  showNum,
  output logic        pending,
  output logic        frame_done
);

  localparam int            CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DWELL_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW:0]   BLANK_LIM = (CW + 1)'(BLANK_CYCLES);
  localparam logic [5:0]    LAMP_CODE = 6'b101111;

  logic [CW-1:0] dwell_q, dwell_d;
  logic [1:0]    pos_q, pos_d;
  logic [15:0]   act_dig_q, act_dig_d;
  logic [3:0]    act_dp_q, act_dp_d;
  logic [15:0]   pend_dig_q, pend_dig_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_vld_q, pend_vld_d;
  logic [3:0]    show_digit_q, show_digit_d;
  logic [5:0]    show_num_q, show_num_d;
  logic          frame_done_q, frame_done_d;
  logic          wrap_s;
  logic          boundary_s;
  logic          blank_s;

  function automatic logic [3:0] pick_nibble(input logic [15:0] v, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = v[3:0];
      2'd1:    nib = v[7:4];
      2'd2:    nib = v[11:8];
      2'd3:    nib = v[15:12];
      default: nib = 4'd0;
    endcase
    return nib;
  endfunction

  // Next-state for scan position, buffers, and the registered outputs.
  always_comb begin
    wrap_s       = (dwell_q == DWELL_MAX);
    boundary_s   = wrap_s && (pos_q == 2'd3);
    dwell_d      = wrap_s ? {CW{1'b0}} : dwell_q + CW'(1);
    pos_d        = wrap_s ? pos_q + 2'd1 : pos_q;
    act_dig_d    = act_dig_q;
    act_dp_d     = act_dp_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_vld_d   = pend_vld_q;

    // A load on the boundary bypasses the buffer and discards anything older.
    if (load) begin
      if (boundary_s) begin
        act_dig_d  = digits_in;
        act_dp_d   = dp_in;
        pend_vld_d = 1'b0;
      end else begin
        pend_dig_d = digits_in;
        pend_dp_d  = dp_in;
        pend_vld_d = 1'b1;
      end
    end else if (boundary_s && pend_vld_q) begin
      act_dig_d  = pend_dig_q;
      act_dp_d   = pend_dp_q;
      pend_vld_d = 1'b0;
    end else begin
      pend_vld_d = pend_vld_q;
    end

    blank_s      = ({1'b0, dwell_d} < BLANK_LIM);
    show_digit_d = {2'b00, pos_d} + 4'd1;
    if (lamp_test) begin
      show_num_d = LAMP_CODE;
    end else if (blank_s) begin
      show_num_d = 6'b000000;
    end else begin
      show_num_d = {act_dp_d[pos_d], 1'b0, pick_nibble(act_dig_d, pos_d)};
    end
    frame_done_d = boundary_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q      <= {CW{1'b0}};
      pos_q        <= 2'd0;
      act_dig_q    <= 16'h0000;
      act_dp_q     <= 4'b0000;
      pend_dig_q   <= 16'h0000;
      pend_dp_q    <= 4'b0000;
      pend_vld_q   <= 1'b0;
      show_digit_q <= 4'd1;
      show_num_q   <= 6'b000000;
      frame_done_q <= 1'b0;
    end else begin
      dwell_q      <= dwell_d;
      pos_q        <= pos_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      show_digit_q <= show_digit_d;
      show_num_q   <= show_num_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign showDigit  = show_digit_q;
  assign showNum    = show_num_q;
  assign pending    = pend_vld_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed self-checking bench for digit_scan_ctrl with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_digit_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic        lamp_test = 1'b0;
  logic [3:0]  showDigit;
  logic [5:0]  showNum;
  logic        pending;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int kc = 0;

  digit_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .lamp_test(lamp_test), .showDigit(showDigit), .showNum(showNum),
    .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    kc++;
  endtask

  task automatic advance_to(input int ph);
    step();
    while ((kc % 32) != ph) step();
  endtask

  // Expected showNum for a frame phase 0..31 with no lamp test.
  function automatic logic [5:0] exp_show(input logic [15:0] dg, input logic [3:0] dpv, input int ph);
    int d;
    int p;
    d = ph % 8;
    p = ph / 8;
    if (d < 2) return 6'd0;
    return {dpv[p], 1'b0, dg[p*4 +: 4]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (showDigit !== 4'd1) begin errors++; $display("FAIL reset_digit got=%0d exp=1", showDigit); end
    checks++; if (showNum !== 6'd0) begin errors++; $display("FAIL reset_num got=%0d exp=0", showNum); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%0b exp=0", pending); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
    rst = 1'b0;
    kc = 0;
  endtask

  task automatic test_scan();
    for (int k = 0; k <= 64; k++) begin
      checks++;
      if (showDigit !== 4'(((k / 8) % 4) + 1)) begin
        errors++; $display("FAIL scan_digit k=%0d got=%0d exp=%0d", k, showDigit, ((k / 8) % 4) + 1);
      end
      checks++;
      if (showNum !== 6'd0) begin errors++; $display("FAIL scan_num k=%0d got=%0d exp=0", k, showNum); end
      checks++;
      if (frame_done !== ((k > 0) && (k % 32 == 0))) begin
        errors++; $display("FAIL scan_frame_done k=%0d got=%0b exp=%0b", k, frame_done, (k > 0) && (k % 32 == 0));
      end
      if (k < 64) step();
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] dg, input logic [3:0] dpv);
    for (int ph = 0; ph < 32; ph++) begin
      checks++;
      if (showNum !== exp_show(dg, dpv, ph)) begin
        errors++; $display("FAIL %s ph=%0d got=%b exp=%b", name, ph, showNum, exp_show(dg, dpv, ph));
      end
      checks++;
      if (pending !== 1'b0) begin errors++; $display("FAIL %s_pending ph=%0d got=%0b exp=0", name, ph, pending); end
      step();
    end
  endtask

  task automatic test_basic_load();
    advance_to(10);
    load = 1'b1; digits_in = 16'h4321; dp_in = 4'b0010;
    step();
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL basic_pending_set got=%0b exp=1", pending); end
    advance_to(31);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL basic_pending_hold got=%0b exp=1", pending); end
    step();
    checks++; if (showNum !== 6'd0) begin errors++; $display("FAIL basic_first_blank got=%b exp=000000", showNum); end
    check_frame("basic_frame", 16'h4321, 4'b0010);
  endtask

  task automatic test_double_load();
    advance_to(3);
    load = 1'b1; digits_in = 16'h1111; dp_in = 4'b0000;
    step();
    load = 1'b0;
    advance_to(20);
    load = 1'b1; digits_in = 16'h9999; dp_in = 4'b0000;
    step();
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL double_pending got=%0b exp=1", pending); end
    advance_to(0);
    check_frame("double_frame", 16'h9999, 4'b0000);
  endtask

  task automatic test_boundary_load();
    advance_to(5);
    load = 1'b1; digits_in = 16'h2222; dp_in = 4'b0000;
    step();
    load = 1'b0;
    advance_to(31);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL boundary_pre_pending got=%0b exp=1", pending); end
    load = 1'b1; digits_in = 16'h5555; dp_in = 4'b1000;
    step();
    load = 1'b0;
    check_frame("boundary_frame1", 16'h5555, 4'b1000);
    check_frame("boundary_frame2", 16'h5555, 4'b1000);
  endtask

  task automatic test_lamp_test();
    advance_to(7);
    lamp_test = 1'b1;
    checks++;
    if (showNum !== exp_show(16'h5555, 4'b1000, 7)) begin
      errors++; $display("FAIL lamp_latency got=%b exp=%b", showNum, exp_show(16'h5555, 4'b1000, 7));
    end
    for (int ph = 8; ph <= 12; ph++) begin
      step();
      checks++;
      if (showNum !== 6'b101111) begin errors++; $display("FAIL lamp_on ph=%0d got=%b exp=101111", ph, showNum); end
    end
    lamp_test = 1'b0;
    step();
    checks++;
    if (showNum !== 6'b000101) begin errors++; $display("FAIL lamp_release got=%b exp=000101", showNum); end
    advance_to(15);
    lamp_test = 1'b1;
    step();
    checks++;
    if (showNum !== 6'b101111) begin errors++; $display("FAIL lamp_on_blank got=%b exp=101111", showNum); end
    lamp_test = 1'b0;
    step();
    checks++;
    if (showNum !== 6'b000000) begin errors++; $display("FAIL lamp_release_blank got=%b exp=000000", showNum); end
  endtask

  task automatic test_reset_mid();
    advance_to(18);
    load = 1'b1; digits_in = 16'h7777; dp_in = 4'b1111;
    step();
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL mid_pending_pre got=%0b exp=1", pending); end
    checks++; if (showDigit !== 4'd3) begin errors++; $display("FAIL mid_pos_pre got=%0d exp=3", showDigit); end
    #2 rst = 1'b1;
    #1;
    checks++; if (showDigit !== 4'd1) begin errors++; $display("FAIL mid_async_digit got=%0d exp=1", showDigit); end
    checks++; if (showNum !== 6'd0) begin errors++; $display("FAIL mid_async_num got=%b exp=000000", showNum); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL mid_async_pending got=%0b exp=0", pending); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_async_frame_done got=%0b exp=0", frame_done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    kc = 0;
    for (int k = 0; k <= 8; k++) begin
      checks++;
      if (showDigit !== ((k < 8) ? 4'd1 : 4'd2)) begin
        errors++; $display("FAIL mid_restart k=%0d got=%0d exp=%0d", k, showDigit, (k < 8) ? 1 : 2);
      end
      checks++;
      if (pending !== 1'b0) begin errors++; $display("FAIL mid_restart_pending k=%0d got=%0b exp=0", k, pending); end
      checks++;
      if (showNum !== 6'd0) begin errors++; $display("FAIL mid_restart_num k=%0d got=%b exp=000000", k, showNum); end
      if (k < 8) step();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_basic_load();
    test_double_load();
    test_boundary_load();
    test_lamp_test();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Upstream scan controller for the four-digit common-anode seven-segment display. It holds a double-buffered four-digit value, time-multiplexes it one digit at a time, and drives the digit-select (`showDigit`) and digit-code (`showNum`) inputs of the segment/anode decoder stage. New values take effect only at frame boundaries, so the display never shows a mix of two values. It also blanks at each digit change to suppress ghosting.

## Interface

**Parameters**
- `SCAN_DIV`, default 4096: clocks per digit dwell. Must be ≥ 2.
- `BLANK_CYCLES`, default 16: clocks at the start of each dwell during which the digit is blanked. Legal range is 0 to `SCAN_DIV`-1.

**Ports**
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `load`, input, 1: one-cycle strobe that captures `digits_in` and `dp_in`.
- `digits_in`, input, 16: four 4-bit digit codes; nibble k-1 (bits 4k-1 to 4k-4) goes to digit position k (k = 1..4).
- `dp_in`, input, 4: decimal point per position; bit k-1 goes to position k.
- `lamp_test`, input, 1: level; forces every digit to all-segments-on plus dp.
- `showDigit`, output, 4: position select to the decoder, values 1..4 only.
- `showNum`, output, 6: bits [3:0] digit code, bit 4 = 0, bit 5 = decimal point.
- `pending`, output, 1: a loaded value is waiting for the frame boundary.
- `frame_done`, output, 1: one-cycle pulse at the end of position 4's dwell.

## Operation

**State**
- `dwell_cnt`: 0 to `SCAN_DIV`-1.
- `pos`: 1..4.
- `active_digits` / `active_dp`: the value being displayed.
- `pend_digits` / `pend_dp`: the buffered value, with its valid flag `pending`.

**Scan sequence**
- `dwell_cnt` increments every clock.
- When `dwell_cnt` = `SCAN_DIV`-1: `dwell_cnt` goes to 0 and `pos` advances 1→2→3→4→1.
- Frame boundary = the edge where `pos` = 4 and `dwell_cnt` = `SCAN_DIV`-1.

**Output formation**
- `showDigit` = `pos`.
- While `lamp_test` = 1: `showNum` = 6'b101111, regardless of the blank window.
- Otherwise, during the blank window (`dwell_cnt` < `BLANK_CYCLES`): `showNum` = 6'b000000. Code 0 is the decoder's blank code.
- Otherwise: `showNum` = {`active_dp`[pos-1], 1'b0, `active_digits` nibble for `pos`}.
- Nibble codes 10–15 pass through unchanged; the decoder shows them as all-on.

**Load handshake (buffer priority per edge)**
- `load`=1 on a frame-boundary edge: `digits_in`/`dp_in` go straight into active; `pending` is cleared. Any older pending value is discarded.
- `load`=1 on any other edge: the data goes into pend; `pending` is set. A load while `pending`=1 overwrites the buffer (last load wins).
- `load`=0 on a frame-boundary edge with `pending`=1: pend is copied to active; `pending` is cleared.
- `pending`=0 with no load: active holds.

**Reset (async; also mid-frame)**
- Outputs: `showDigit`=1, `showNum`=0, `pending`=0, `frame_done`=0.
- Internal: `dwell_cnt`=0, `pos`=1, active=0, pend=0.
- An in-flight pending value is lost.

## Timing

- All outputs are registered. Each is computed from next-state values, so it changes on the same edge as `pos`/`dwell_cnt`/active.
- After reset release, `showDigit` holds each position for exactly `SCAN_DIV` clocks. The first 1→2 change is at the `SCAN_DIV`-th rising edge.
- Frame period = 4×`SCAN_DIV` clocks.
- `frame_done` is high for exactly the one cycle following each frame-boundary edge.
- New data appears at position 1 in the first cycle after the boundary edge, still subject to the blank window. Worst-case load-to-display latency is 4×`SCAN_DIV` clocks.
- `lamp_test` takes effect on the next edge: one cycle of latency, with no dependence on the frame.
- With `BLANK_CYCLES`=0 there is no blanking.

## Test plan

All scenarios use `SCAN_DIV`=8, `BLANK_CYCLES`=2.

1. **Reset and scan.** Reset, then release with no load. Required: `showDigit` sequence is 1×8, 2×8, 3×8, 4×8, repeating; `showNum`=0 throughout; `frame_done` pulses every 32 clocks.
2. **Basic load.** Pulse `load` mid-frame with `digits_in`=16'h4321, `dp_in`=4'b0010. Required: `pending`=1 until the boundary. In the next frame, position k shows code 0 for 2 clocks, then `showNum` = 6'd1, then 6'b100010 (dp set), then 6'd3, then 6'd4, each for the remaining 6 clocks of its dwell.
3. **Double load.** Load 16'h1111, then load 16'h9999 before the boundary. Required: only 9s are ever displayed.
4. **Load on the boundary edge.** Load 16'h5555 with `pending`=1 holding 16'h2222. Required: the next frame shows 5s; `pending`=0; 2 is never shown.
5. **Lamp test.** Assert `lamp_test` during a blank window. Required: `showNum`=6'b101111 on the next cycle and while held. Deasserting it returns the normal value, or 0 if still inside the blank window.
6. **Reset mid-operation.** Assert `rst` at `pos`=3 with `pending`=1. Required: outputs go to reset values immediately, without waiting for a clock; after release, `pending`=0 and the scan restarts at position 1 with a full 8-clock dwell.
